// File: rtl/clk_div_pkg.sv
// Shared types, reset defaults and config clamping for the programmable clock divider.
package clk_div_pkg;

  localparam int CNT_W_DEF    = 28;
  localparam int DEF_DIV_VAL  = 25;
  localparam int DEF_HIGH_VAL = 12;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] div;
    logic [CNT_W_DEF-1:0] high;
  } ch_cfg_t;

  // A period below 2 cannot toggle; a high time beyond the period saturates to always-high.
  function automatic ch_cfg_t clamp_cfg(input logic [CNT_W_DEF-1:0] div,
                                        input logic [CNT_W_DEF-1:0] high);
    ch_cfg_t c;
    c.div  = (div < CNT_W_DEF'(2)) ? CNT_W_DEF'(2) : div;
    c.high = (high > c.div) ? c.div : high;
    return c;
  endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Configuration write port (valid/ready) of the programmable clock divider.
interface clk_div_prog_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 28
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_high;

  modport master (output cfg_valid, output cfg_ch, output cfg_div, output cfg_high,
                  input cfg_ready);
  modport slave  (input cfg_valid, input cfg_ch, input cfg_div, input cfg_high,
                  output cfg_ready);
endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, active/shadow config and registered PWM/tick outputs.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int DEF_DIV  = DEF_DIV_VAL,
  parameter int DEF_HIGH = DEF_HIGH_VAL
) (
  input  logic    clk_in,
  input  logic    rst,
  input  logic    en,
  input  logic    sync,
  input  logic    wr_en,
  input  ch_cfg_t wr_cfg,
  output logic    pending,
  output logic    clk_out,
  output logic    tick
);

  localparam ch_cfg_t DEF_CFG = '{div: CNT_W_DEF'(DEF_DIV), high: CNT_W_DEF'(DEF_HIGH)};

  logic [CNT_W_DEF-1:0] cnt_r;
  ch_cfg_t              act_r;
  ch_cfg_t              shadow_r;
  logic                 pending_r;
  logic                 clk_out_r;
  logic                 tick_r;
  logic                 wrap_s;
  logic                 apply_s;

  assign wrap_s  = en && (cnt_r == (act_r.div - CNT_W_DEF'(1)));
  assign apply_s = wrap_s || sync;

  // A write landing on the apply edge stays pending: the apply takes the shadow as it was.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_r     <= CNT_W_DEF'(0);
      act_r     <= DEF_CFG;
      shadow_r  <= DEF_CFG;
      pending_r <= 1'b0;
      clk_out_r <= 1'b0;
      tick_r    <= 1'b0;
    end else begin
      if (en) begin
        clk_out_r <= (cnt_r < act_r.high);
      end
      tick_r <= en && (cnt_r == CNT_W_DEF'(0));
      if (apply_s) begin
        cnt_r <= CNT_W_DEF'(0);
        act_r <= shadow_r;
      end else if (en) begin
        cnt_r <= cnt_r + CNT_W_DEF'(1);
      end
      if (wr_en) begin
        shadow_r  <= wr_cfg;
        pending_r <= 1'b1;
      end else if (apply_s) begin
        pending_r <= 1'b0;
      end
    end
  end

  assign pending = pending_r;
  assign clk_out = clk_out_r;
  assign tick    = tick_r;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel runtime-programmable clock divider; configs apply only at period boundaries.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEF_DIV  = DEF_DIV_VAL,
  parameter int DEF_HIGH = DEF_HIGH_VAL
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  input  logic              sync,
  clk_div_prog_if.slave     cfg,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] pending_s;
  logic [NUM_CH-1:0] wr_en_s;
  logic              ready_s;
  ch_cfg_t           wr_cfg_s;

  assign wr_cfg_s = clamp_cfg(cfg.cfg_div, cfg.cfg_high);

  // Out-of-range channel numbers read as ready and match no channel, so the write is dropped.
  always_comb begin
    ready_s = 1'b1;
    wr_en_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      ready_s = (int'(cfg.cfg_ch) == i) ? !pending_s[i] : ready_s;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      wr_en_s[i] = cfg.cfg_valid && ready_s && (int'(cfg.cfg_ch) == i);
    end
  end

  assign cfg.cfg_ready = ready_s;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .DEF_DIV  (DEF_DIV),
      .DEF_HIGH (DEF_HIGH)
    ) u_ch (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (en),
      .sync    (sync),
      .wr_en   (wr_en_s[g]),
      .wr_cfg  (wr_cfg_s),
      .pending (pending_s[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed plus randomized bench for clk_div_prog against a cycle-level behavioural model.
module tb_clk_div_prog;
  import clk_div_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 28;
  localparam int CH_W   = 2;

  logic              clk_in = 1'b0;
  logic              rst;
  logic              en;
  logic              sync;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  clk_div_prog_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg_if ();

  clk_div_prog #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_DIV(25), .DEF_HIGH(12)) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .en      (en),
    .sync    (sync),
    .cfg     (cfg_if),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // model: position inside the current period, active and shadow settings, pending flag
  int m_pos   [NUM_CH];
  int m_div   [NUM_CH];
  int m_high  [NUM_CH];
  int m_sdiv  [NUM_CH];
  int m_shigh [NUM_CH];
  bit m_pend  [NUM_CH];
  bit m_clk   [NUM_CH];
  bit m_tick  [NUM_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_pos[c] = 0; m_div[c] = 25; m_high[c] = 12;
      m_sdiv[c] = 25; m_shigh[c] = 12; m_pend[c] = 1'b0;
      m_clk[c] = 1'b0; m_tick[c] = 1'b0;
    end
  endtask

  function automatic logic exp_ready();
    int ch = int'(cfg_if.cfg_ch);
    return (ch < NUM_CH) ? !m_pend[ch] : 1'b1;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_clk();
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_clk[c];
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_tick();
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_tick[c];
    return v;
  endfunction

  // One clock edge of the spec's rules, using the inputs currently on the pins.
  task automatic model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      bit wrap, apply, acc;
      int d, h;
      wrap  = en && (m_pos[c] == m_div[c] - 1);
      apply = wrap || sync;
      acc   = cfg_if.cfg_valid && (int'(cfg_if.cfg_ch) == c) && !m_pend[c];
      if (en) m_clk[c] = (m_pos[c] < m_high[c]);
      m_tick[c] = en && (m_pos[c] == 0);
      if (apply) begin
        m_pos[c] = 0; m_div[c] = m_sdiv[c]; m_high[c] = m_shigh[c];
      end else if (en) begin
        m_pos[c] = m_pos[c] + 1;
      end
      if (acc) begin
        d = (int'(cfg_if.cfg_div) < 2) ? 2 : int'(cfg_if.cfg_div);
        h = (int'(cfg_if.cfg_high) > d) ? d : int'(cfg_if.cfg_high);
        m_sdiv[c] = d; m_shigh[c] = h; m_pend[c] = 1'b1;
      end else if (apply) begin
        m_pend[c] = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk_in);
    check("cfg_ready", 32'(cfg_if.cfg_ready), 32'(exp_ready()));
    model_step();
    @(posedge clk_in);
    #1;
    check("clk_out", 32'(clk_out), 32'(exp_clk()));
    check("tick", 32'(tick), 32'(exp_tick()));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic write_cfg(input int ch, input int div, input int high);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = CH_W'(ch);
    cfg_if.cfg_div   = CNT_W'(div);
    cfg_if.cfg_high  = CNT_W'(high);
    cycle();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic count_high(input int ch, input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      highs += int'(clk_out[ch]);
    end
  endtask

  initial begin
    int highs, ticks, misalign, t_first, t_second;
    logic prev;

    rst = 1'b1; en = 1'b0; sync = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_div = '0; cfg_if.cfg_high = '0;
    model_reset();
    #12;
    check("reset_clk_out", 32'(clk_out), 32'h0);
    check("reset_tick", 32'(tick), 32'h0);
    check("reset_ready", 32'(cfg_if.cfg_ready), 32'h1);

    // 1: defaults give 12 high / 13 low, ticks on the rising edge
    @(posedge clk_in); #1;
    rst = 1'b0; en = 1'b1;
    highs = 0; ticks = 0; misalign = 0; prev = 1'b0;
    for (int k = 0; k < 50; k++) begin
      cycle();
      highs += int'(clk_out[0]);
      ticks += int'(tick[0]);
      if (tick[0] && !(clk_out[0] && !prev)) misalign++;
      prev = clk_out[0];
    end
    check("default_highs_50", 32'(highs), 32'd24);
    check("default_ticks_50", 32'(ticks), 32'd2);
    check("tick_on_rise", 32'(misalign), 32'd0);

    // 2: mid-period reprogram of ch1
    run(10);
    write_cfg(1, 10, 3);
    run(30);
    count_high(1, 20, highs);
    check("ch1_highs_2per", 32'(highs), 32'd6);
    count_high(0, 25, highs);
    check("ch0_unaffected", 32'(highs), 32'd12);

    // 3: clamping, then zero duty
    write_cfg(2, 0, 5);
    run(30);
    count_high(2, 10, highs);
    check("clamp_const_high", 32'(highs), 32'd10);
    write_cfg(2, 4, 0);
    run(10);
    count_high(2, 10, highs);
    check("zero_duty_low", 32'(highs), 32'd0);

    // 4: write to a pending channel is refused, retry after apply is taken
    write_cfg(3, 8, 4);
    write_cfg(3, 6, 1);
    run(30);
    write_cfg(3, 6, 1);
    run(20);

    // 5: accept+sync together, then sync applying a pending config
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd3; cfg_if.cfg_div = 28'd9; cfg_if.cfg_high = 28'd4;
    sync = 1'b1;
    cycle();
    cfg_if.cfg_valid = 1'b0; sync = 1'b0;
    run(3);
    write_cfg(0, 5, 2);
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    cycle();
    check("sync_align_tick", 32'(tick), 32'hF);
    run(30);

    // sync while frozen still restarts and applies
    write_cfg(1, 7, 2);
    en = 1'b0; sync = 1'b1;
    cycle();
    sync = 1'b0;
    run(2);
    en = 1'b1;
    run(20);

    // 6: freeze during high phase stretches the period by exactly 7
    @(posedge clk_in); #1;
    rst = 1'b1;
    @(posedge clk_in); #1;
    model_reset();
    rst = 1'b0;
    t_first = -1; t_second = -1;
    for (int k = 0; k < 60; k++) begin
      en = (k >= 5 && k <= 11) ? 1'b0 : 1'b1;
      cycle();
      if (k >= 5 && k <= 11) check("freeze_high", 32'(clk_out[0]), 32'h1);
      if (tick[0] && t_first < 0) t_first = k;
      else if (tick[0] && t_second < 0) t_second = k;
    end
    check("stretched_period", 32'(t_second - t_first), 32'd32);
    en = 1'b1;

    // randomized config traffic, sync and enable gaps
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      sync = ($urandom_range(0, 39) == 0);
      cfg_if.cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_if.cfg_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
      cfg_if.cfg_div   = CNT_W'($urandom_range(0, 12));
      cfg_if.cfg_high  = CNT_W'($urandom_range(0, 14));
      cycle();
    end
    cfg_if.cfg_valid = 1'b0; sync = 1'b0; en = 1'b1;
    run(5);

    // asynchronous reset mid-period
    @(posedge clk_in); #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_clk_out", 32'(clk_out), 32'h0);
    check("async_rst_tick", 32'(tick), 32'h0);
    check("async_rst_ready", 32'(cfg_if.cfg_ready), 32'h1);
    @(posedge clk_in); #1;
    rst = 1'b0;
    run(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
